apb_timer_multi: RTL and testbench
==================================

// Module: apb_timer_multi
// PURPOSE
//  Parametrised multi-channel APB timer, successor to the single 8-bit timer.
//  NUM_CH independent up/down counters of WIDTH bits share one prescaler.
//  Each channel adds auto-reload, interrupt enables and a readable count.
//  Sits on the peripheral APB bus; irq[] goes to the interrupt controller.
// PARAMETERS
//  WIDTH   8  counter, TDR and APB data width (8..32)
//  NUM_CH  2  number of timer channels (1..8)
// PORTS
//  pclk     in   1            bus/timer clock; all logic on its rising edge
//  preset   in   1            synchronous, active-high reset
//  psel     in   1            APB select
//  penable  in   1            APB access phase
//  pwrite   in   1            1 = write, 0 = read
//  paddr    in   8            byte address
//  pwdata   in   WIDTH        write data
//  prdata   out  WIDTH        read data
//  pready   out  1            tied 1 (zero wait state)
//  pslverr  out  1            error on access to an unmapped address
//  irq      out  NUM_CH       per-channel level interrupt
// BEHAVIOUR
//  Map: channel n base = 8*n. +0 TDR (RW), +1 TCR (RW), +2 TSR (RW0C),
//   +3 TIER (RW, bits[1:0]), +4 TCNT (RO). Other offsets/channels unmapped.
//  TCR bits: [7] LOAD, [5] DW (1 = down), [4] EN, [3] ARE (auto-reload),
//   [1:0] CKS. Other bits read 0.
//  TSR bits: [0] OVF, [1] UDF. TIER bits: [0] OVF enable, [1] UDF enable.
//  APB write commits on the cycle with psel&penable&pwrite.
//  prdata is combinational when psel&!pwrite, else 0. Unmapped reads give 0.
//  pslverr = psel&penable&unmapped. A write to an unmapped address or to
//   TCNT is ignored.
//  Prescaler: free-running 4-bit counter, cleared only by reset.
//   Tick for CKS=k fires when its low k+1 bits are all 1s, i.e. every
//   pclk/2, /4, /8, /16. A CKS change applies from the next tick.
//  LOAD is a strobe and always reads back 0. Writing 1 copies TDR into TCNT
//   in the following cycle. The other TCR bits in that write take effect
//   normally.
//  Counting happens only on a tick with EN=1. With EN=0, TCNT holds.
//  Up count: at TCNT = 2^WIDTH-1 the next TCNT is 0 (ARE=0) or TDR (ARE=1),
//   and OVF is set.
//  Down count: at TCNT = 0 the next TCNT is 2^WIDTH-1 (ARE=0) or TDR (ARE=1),
//   and UDF is set.
//  Priority per cycle: reset > LOAD > tick count. A load that coincides with a
//   tick suppresses that count and raises no flag.
//  OVF/UDF are sticky. Writing 0 to a bit clears it; writing 1 has no effect.
//   A hardware set in the same cycle as a clear wins (flag stays 1).
//  irq[n] = |(TSR[n][1:0] & TIER[n][1:0]), registered (1-cycle latency from
//   the flag).
//  Reset (any cycle, including mid-count): TDR, TCR, TSR, TIER, TCNT and the
//   prescaler go to 0; irq = 0. The next count starts from the reset state.
//  Channels are fully independent apart from the shared prescaler phase.
// TESTING
//  1 ch0: TDR=8'hFF, TCR=8'h80, then TCR=8'h30 (down, EN, /2)
//    -> TSR=8'h00 after 500 pclk, TSR=8'h02 after 512 pclk, TCNT=8'hFF.
//  2 ch1: TDR=8'hF0, TCR=8'h98 (load, EN, ARE, up, /2) -> OVF after
//    32 pclk (+/-1 tick), TCNT reloads 8'hF0; ch0 TSR stays 8'h00.
//  3 UDF set, TIER=2'b10 -> irq[0]=1 one cycle later; write TSR=8'h00 in
//    the same cycle as a new UDF -> TSR stays 8'h02.
//  4 CKS sweep 00..11, up from 0, EN for 64 pclk -> TCNT = 32/16/8/4 (+/-1).
//  5 EN=1 counting, assert preset 1 cycle mid-count -> all regs and irq
//    read 0, TCNT frozen at 0.
//  6 read/write paddr=8'h05 with NUM_CH=1 -> pslverr=1, prdata=0,
//    no register changes; WIDTH=16 run of test 1 -> UDF after 2*65536 pclk.

Source files
------------

// File: rtl/apb_timer_multi.sv
// ============================================================================
// apb_timer_multi
//   NUM_CH independent WIDTH-bit up/down timers behind a zero-wait-state APB
//   slave. All channels share one free-running 4-bit prescaler. Each channel
//   has a reload register (TDR), a control register (TCR), sticky flags (TSR),
//   interrupt enables (TIER) and a read-only live count (TCNT).
//
//   Channel n register block at byte address 8*n:
//     +0 TDR  (RW)   reload / load value
//     +1 TCR  (RW)   [7] LOAD strobe, [5] DW, [4] EN, [3] ARE, [1:0] CKS
//     +2 TSR  (RW0C) [0] OVF, [1] UDF
//     +3 TIER (RW)   [0] OVF enable, [1] UDF enable
//     +4 TCNT (RO)   current count
//
// Ports
//   pclk     in   bus/timer clock, rising edge
//   preset   in   synchronous active-high reset
//   psel     in   APB select
//   penable  in   APB access phase
//   pwrite   in   1 = write, 0 = read
//   paddr    in   [7:0] byte address
//   pwdata   in   [WIDTH-1:0] write data
//   prdata   out  [WIDTH-1:0] read data (combinational)
//   pready   out  always 1
//   pslverr  out  access to an unmapped address
//   irq      out  [NUM_CH-1:0] registered level interrupt per channel
// ============================================================================
module apb_timer_multi #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 2
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [7:0]        paddr,
    input  logic [WIDTH-1:0]  pwdata,
    output logic [WIDTH-1:0]  prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [NUM_CH-1:0] irq
);

    localparam logic [2:0] OFF_TDR  = 3'd0;
    localparam logic [2:0] OFF_TCR  = 3'd1;
    localparam logic [2:0] OFF_TSR  = 3'd2;
    localparam logic [2:0] OFF_TIER = 3'd3;
    localparam logic [2:0] OFF_TCNT = 3'd4;

    logic [4:0]       ch_sel;
    logic [2:0]       off;
    logic             ch_ok;
    logic             off_ok;
    logic             mapped;
    logic             wr_en;
    logic [3:0]       presc;
    logic [3:0]       tick_vec;
    logic [WIDTH-1:0] rd_ch [NUM_CH];

    assign ch_sel  = paddr[7:3];
    assign off     = paddr[2:0];
    assign ch_ok   = 32'(ch_sel) < 32'(NUM_CH);
    assign off_ok  = off <= OFF_TCNT;
    assign mapped  = ch_ok && off_ok;
    assign wr_en   = psel && penable && pwrite && mapped;
    assign pready  = 1'b1;
    assign pslverr = psel && penable && !mapped;

    // Shared prescaler; only reset clears it, so channel phases stay aligned.
    always_ff @(posedge pclk) begin
        if (preset) begin
            presc <= 4'd0;
        end else begin
            presc <= presc + 4'd1;
        end
    end

    // Tick for CKS=k when the low k+1 prescaler bits are all ones.
    assign tick_vec = {&presc[3:0], &presc[2:0], &presc[1:0], presc[0]};

    always_comb begin
        prdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (psel && !pwrite && off_ok && (ch_sel == 5'(i))) begin
                prdata = rd_ch[i];
            end
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [WIDTH-1:0] tdr_r;
        logic [WIDTH-1:0] tcnt_r;
        logic             dw_r;
        logic             en_r;
        logic             are_r;
        logic [1:0]       cks_r;
        logic [1:0]       tsr_r;
        logic [1:0]       tier_r;
        logic             load_pend;
        logic             irq_r;

        logic             sel;
        logic             tick;
        logic             cnt_en;
        logic [1:0]       hw_set;
        logic [1:0]       clr_mask;
        logic [WIDTH-1:0] cnt_next;
        logic [WIDTH-1:0] rdv;

        assign sel = wr_en && (ch_sel == 5'(n));

        always_comb begin
            tick     = tick_vec[cks_r];
            // A pending load owns TCNT this cycle: no count and no flag.
            cnt_en   = tick && en_r && !load_pend;
            hw_set   = 2'b00;
            cnt_next = tcnt_r;
            if (cnt_en) begin
                if (dw_r) begin
                    if (tcnt_r == '0) begin
                        cnt_next  = are_r ? tdr_r : '1;
                        hw_set[1] = 1'b1;
                    end else begin
                        cnt_next = tcnt_r - 1'b1;
                    end
                end else begin
                    if (tcnt_r == '1) begin
                        cnt_next  = are_r ? tdr_r : '0;
                        hw_set[0] = 1'b1;
                    end else begin
                        cnt_next = tcnt_r + 1'b1;
                    end
                end
            end
        end

        // Writing 0 clears a flag, writing 1 keeps it.
        assign clr_mask = (sel && off == OFF_TSR) ? pwdata[1:0] : 2'b11;

        always_ff @(posedge pclk) begin
            if (preset) begin
                tdr_r     <= '0;
                tcnt_r    <= '0;
                dw_r      <= 1'b0;
                en_r      <= 1'b0;
                are_r     <= 1'b0;
                cks_r     <= 2'b00;
                tsr_r     <= 2'b00;
                tier_r    <= 2'b00;
                load_pend <= 1'b0;
                irq_r     <= 1'b0;
            end else begin
                load_pend <= sel && (off == OFF_TCR) && pwdata[7];
                if (sel && off == OFF_TDR) begin
                    tdr_r <= pwdata;
                end
                if (sel && off == OFF_TCR) begin
                    dw_r  <= pwdata[5];
                    en_r  <= pwdata[4];
                    are_r <= pwdata[3];
                    cks_r <= pwdata[1:0];
                end
                if (sel && off == OFF_TIER) begin
                    tier_r <= pwdata[1:0];
                end
                // Hardware set is OR-ed after the clear so it wins a collision.
                tsr_r  <= (tsr_r & clr_mask) | hw_set;
                tcnt_r <= load_pend ? tdr_r : cnt_next;
                irq_r  <= |(tsr_r & tier_r);
            end
        end

        always_comb begin
            rdv = '0;
            case (off)
                OFF_TDR:  rdv = tdr_r;
                OFF_TCR: begin
                    rdv[5]   = dw_r;
                    rdv[4]   = en_r;
                    rdv[3]   = are_r;
                    rdv[1:0] = cks_r;
                end
                OFF_TSR:  rdv[1:0] = tsr_r;
                OFF_TIER: rdv[1:0] = tier_r;
                OFF_TCNT: rdv = tcnt_r;
                default:  rdv = '0;
            endcase
        end

        assign rd_ch[n] = rdv;
        assign irq[n]   = irq_r;
    end

endmodule

// File: tb/tb_apb_timer_multi.sv
module tb_apb_timer_multi;

    typedef struct {
        string       name;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        err;
    } exp_t;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel_a, psel_b, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [7:0]  prdata_a;
    logic [15:0] prdata_b;
    logic        pready_a, pready_b, pslverr_a, pslverr_b;
    logic [1:0]  irq_a;
    logic [0:0]  irq_b;

    exp_t        apb_q[$];
    logic [2:0]  irq_q[$];
    string       irq_nm_q[$];
    logic        irq_req = 1'b0;
    logic        fin_chk = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    always #5 pclk = ~pclk;

    apb_timer_multi #(.WIDTH(8), .NUM_CH(2)) dut_a (
        .pclk(pclk), .preset(preset), .psel(psel_a), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata[7:0]),
        .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a), .irq(irq_a)
    );

    apb_timer_multi #(.WIDTH(16), .NUM_CH(1)) dut_b (
        .pclk(pclk), .preset(preset), .psel(psel_b), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata[15:0]),
        .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b), .irq(irq_b)
    );

    // Cycle count since reset; its low 4 bits track the prescaler phase.
    always @(posedge pclk) begin
        if (preset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Monitor / scoreboard
    always @(negedge pclk) begin
        logic [31:0] rdv;
        logic        erv, rdyv;
        exp_t        e;
        logic [2:0]  ei;
        string       en;
        if ((psel_a || psel_b) && penable) begin
            rdv  = psel_a ? {24'h0, prdata_a} : {16'h0, prdata_b};
            erv  = psel_a ? pslverr_a : pslverr_b;
            rdyv = psel_a ? pready_a : pready_b;
            n_tests++;
            if (apb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_access addr=%h got=%h", paddr, rdv);
            end else begin
                e = apb_q.pop_front();
                if ($isunknown(rdv) || rdv < e.lo || rdv > e.hi || erv !== e.err || rdyv !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s addr=%h got data=%h err=%b ready=%b expected data=%h..%h err=%b ready=1",
                             e.name, paddr, rdv, erv, rdyv, e.lo, e.hi, e.err);
                end
            end
        end
        if (irq_req) begin
            n_tests++;
            if (irq_q.size() == 0) begin
                n_fail++;
                $display("FAIL irq_unexpected_check got=%b", {irq_b, irq_a});
            end else begin
                ei = irq_q.pop_front();
                en = irq_nm_q.pop_front();
                if ({irq_b, irq_a} !== ei) begin
                    n_fail++;
                    $display("FAIL %s irq got=%b expected=%b", en, {irq_b, irq_a}, ei);
                end
            end
        end
        if (fin_chk) begin
            n_tests++;
            if (apb_q.size() != 0 || irq_q.size() != 0) begin
                n_fail++;
                $display("FAIL leftover_expectations got=%0d/%0d expected=0/0", apb_q.size(), irq_q.size());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge pclk);
    endtask

    task automatic wr(input bit b, input logic [7:0] a, input logic [31:0] d, input logic err);
        @(posedge pclk); #1;
        psel_a = !b; psel_b = b; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        apb_q.push_back('{name: $sformatf("wr_%h", a), lo: 32'h0, hi: 32'h0, err: err});
        @(posedge pclk); #1;
        psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic rd(input bit b, input logic [7:0] a, input logic [31:0] lo,
                      input logic [31:0] hi, input logic err, input string nm);
        @(posedge pclk); #1;
        psel_a = !b; psel_b = b; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge pclk); #1;
        penable = 1'b1;
        apb_q.push_back('{name: nm, lo: lo, hi: hi, err: err});
        @(posedge pclk); #1;
        psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    endtask

    task automatic rdx(input bit b, input logic [7:0] a, input logic [31:0] v, input string nm);
        rd(b, a, v, v, 1'b0, nm);
    endtask

    task automatic chk_irq(input logic [2:0] v, input string nm);
        irq_q.push_back(v);
        irq_nm_q.push_back(nm);
        irq_req = 1'b1;
        @(negedge pclk); #1;
        irq_req = 1'b0;
    endtask

    initial begin
        preset = 1'b1; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = 8'h0; pwdata = 32'h0;
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;

        // reset state
        for (int i = 0; i < 5; i++) begin
            rdx(0, 8'(i), 0, $sformatf("rst_ch0_off%0d", i));
            rdx(0, 8'(8 + i), 0, $sformatf("rst_ch1_off%0d", i));
        end
        chk_irq(3'b000, "rst_irq");

        // 1: ch0 down count from FF, underflow without auto-reload
        wr(0, 8'h00, 32'hFF, 0);
        wr(0, 8'h01, 32'h80, 0);
        rdx(0, 8'h04, 32'hFF, "t1_load_tcnt");
        rdx(0, 8'h01, 32'h00, "t1_load_reads0");
        wr(0, 8'h01, 32'h30, 0);
        idle(495);
        rdx(0, 8'h02, 32'h00, "t1_tsr_early");
        rdx(0, 8'h04, 32'h05, "t1_tcnt_mid");
        idle(9);
        rdx(0, 8'h04, 32'hFF, "t1_tcnt_wrap");
        rdx(0, 8'h02, 32'h02, "t1_tsr_udf");
        rdx(0, 8'h0A, 32'h00, "t1_ch1_tsr");
        wr(0, 8'h01, 32'h00, 0);
        wr(0, 8'h02, 32'h00, 0);
        rdx(0, 8'h02, 32'h00, "t1_tsr_clr");

        // 2: ch1 up count with auto-reload from F0
        wr(0, 8'h08, 32'hF0, 0);
        wr(0, 8'h09, 32'h98, 0);
        idle(27);
        rdx(0, 8'h0A, 32'h00, "t2_tsr_early");
        idle(1);
        rdx(0, 8'h0C, 32'hF0, "t2_tcnt_reload");
        rdx(0, 8'h0A, 32'h01, "t2_tsr_ovf");
        rdx(0, 8'h02, 32'h00, "t2_ch0_tsr");
        rdx(0, 8'h09, 32'h18, "t2_tcr");
        wr(0, 8'h09, 32'h00, 0);
        wr(0, 8'h0A, 32'h00, 0);
        rdx(0, 8'h0A, 32'h00, "t2_tsr_clr");

        // 3: UDF set colliding with a TSR clear, then irq latency
        wr(0, 8'h00, 32'h00, 0);
        wr(0, 8'h01, 32'h80, 0);
        wr(0, 8'h02, 32'h00, 0);
        do begin
            @(posedge pclk); #1;
        end while (cyc % 16 != 5);
        wr(0, 8'h01, 32'h33, 0);
        idle(5);
        wr(0, 8'h02, 32'h00, 0);
        rdx(0, 8'h02, 32'h02, "t3_set_beats_clr");
        rdx(0, 8'h04, 32'hFF, "t3_tcnt");
        wr(0, 8'h02, 32'h02, 0);
        rdx(0, 8'h02, 32'h02, "t3_w1_noeffect");
        wr(0, 8'h03, 32'h02, 0);
        chk_irq(3'b000, "t3_irq_latency");
        chk_irq(3'b001, "t3_irq_set");
        rdx(0, 8'h03, 32'h02, "t3_tier");
        wr(0, 8'h02, 32'h00, 0);
        chk_irq(3'b001, "t3_irq_hold");
        chk_irq(3'b000, "t3_irq_clr");
        rdx(0, 8'h02, 32'h00, "t3_tsr_clr");
        wr(0, 8'h01, 32'h00, 0);

        // 4: CKS sweep on ch1, 64-cycle enable window
        wr(0, 8'h08, 32'h00, 0);
        for (int k = 0; k < 4; k++) begin
            wr(0, 8'h09, 32'h80, 0);
            wr(0, 8'h09, 32'h10 | k, 0);
            idle(61);
            wr(0, 8'h09, 32'(k), 0);
            rdx(0, 8'h0C, 32'(32 >> k), $sformatf("t4_cks%0d_tcnt", k));
            rdx(0, 8'h09, 32'(k), $sformatf("t4_cks%0d_tcr", k));
        end
        rdx(0, 8'h0A, 32'h00, "t4_no_ovf");

        // 5: reset in the middle of counting
        wr(0, 8'h00, 32'hFE, 0);
        wr(0, 8'h01, 32'h80, 0);
        wr(0, 8'h03, 32'h01, 0);
        wr(0, 8'h08, 32'h3C, 0);
        wr(0, 8'h0B, 32'h03, 0);
        wr(0, 8'h01, 32'h10, 0);
        idle(10);
        chk_irq(3'b001, "t5_irq_pre");
        rdx(0, 8'h02, 32'h01, "t5_tsr_pre");
        @(posedge pclk); #1 preset = 1'b1;
        @(posedge pclk); #1 preset = 1'b0;
        idle(3);
        for (int i = 0; i < 5; i++) begin
            rdx(0, 8'(i), 0, $sformatf("t5_ch0_off%0d", i));
            rdx(0, 8'(8 + i), 0, $sformatf("t5_ch1_off%0d", i));
        end
        chk_irq(3'b000, "t5_irq_post");
        idle(20);
        rdx(0, 8'h04, 32'h00, "t5_tcnt_frozen");

        // 6: unmapped accesses and ignored TCNT write
        rd(0, 8'h05, 0, 0, 1, "t6_a_rd05");
        rd(0, 8'h10, 0, 0, 1, "t6_a_rd10");
        wr(0, 8'h05, 32'hAA, 1);
        wr(0, 8'h04, 32'h77, 0);
        rdx(0, 8'h04, 32'h00, "t6_a_tcnt_ro");
        rd(1, 8'h05, 0, 0, 1, "t6_b_rd05");
        rd(1, 8'h08, 0, 0, 1, "t6_b_rd08");
        wr(1, 8'h05, 32'hABCD, 1);
        wr(1, 8'h08, 32'h1234, 1);
        for (int i = 0; i < 5; i++) begin
            rdx(1, 8'(i), 0, $sformatf("t6_b_off%0d", i));
        end

        // 6b: 16-bit channel down count through the wrap
        wr(1, 8'h00, 32'h0100, 0);
        wr(1, 8'h01, 32'h80, 0);
        rdx(1, 8'h04, 32'h0100, "t6_b_load");
        wr(1, 8'h01, 32'h30, 0);
        idle(510);
        rdx(1, 8'h04, 32'h0000, "t6_b_tcnt_zero");
        rdx(1, 8'h02, 32'h0002, "t6_b_udf");
        rdx(1, 8'h04, 32'hFFFD, "t6_b_tcnt_wrap");
        rdx(1, 8'h01, 32'h0030, "t6_b_tcr");
        chk_irq(3'b000, "t6_irq_none");

        idle(2);
        fin_chk = 1'b1;
        @(negedge pclk); #1;
        fin_chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
